clint: RTL and testbench

Core-local interrupt generator: the machine timer (`mtime` / `mtimecmp`) and the machine software-interrupt register (`msip`), behind a single-outstanding load/store slave port. It drives the `int_timer_i` and `int_soft_i` inputs of the trap-entry logic, which gates them with `mie` / `mstatus.MIE` and records the trap. It sits on the data-memory side of the core.

---
 rtl/clint.sv | 161 ++++++++++++++++
 tb/tb_clint.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clint.sv
// clint: machine timer (mtime/mtimecmp) and software interrupt (msip) on a load/store slave port.
// Latency: response 1 cycle after accept; int_timer_o is a registered mtime >= mtimecmp compare.
// Backpressure: one response outstanding, req_ready_o = ~rsp_valid_o | rsp_ready_i. CLINT_PRESCALE_EN adds the TICK_DIV prescaler.

module clint
`ifdef CLINT_PRESCALE_EN
#(
  parameter int unsigned TICK_DIV = 1
)
`endif
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [15:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [3:0]  req_be_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        int_soft_o,
  output logic        int_timer_o
);

  localparam logic [15:0] ADDR_MSIP     = 16'h0000;
  localparam logic [15:0] ADDR_CMP_LO   = 16'h4000;
  localparam logic [15:0] ADDR_CMP_HI   = 16'h4004;
  localparam logic [15:0] ADDR_MTIME_LO = 16'hBFF8;
  localparam logic [15:0] ADDR_MTIME_HI = 16'hBFFC;

  typedef enum logic {IDLE, RESP} state_t;

  state_t      state_q, state_d;
  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic        msip_q, msip_d;
  logic        timer_q;
  logic [31:0] rsp_rdata_q;
  logic        rsp_err_q;

  logic        accept;
  logic        sel_msip, sel_cmp_lo, sel_cmp_hi, sel_mtime_lo, sel_mtime_hi;
  logic        hit;
  logic        wr_en;
  logic        mtime_wr;
  logic        tick;
  logic [31:0] rd_data;

  function automatic logic [31:0] merge_be(input logic [31:0] old_val,
                                           input logic [31:0] new_val,
                                           input logic [3:0]  be);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[i*8 +: 8] = new_val[i*8 +: 8];
    end
    return res;
  endfunction

  assign rsp_valid_o = (state_q == RESP);
  assign req_ready_o = ~rsp_valid_o | rsp_ready_i;
  assign accept      = req_valid_i & req_ready_o;

  // Full-address compares also reject misaligned offsets.
  assign sel_msip     = (req_addr_i == ADDR_MSIP);
  assign sel_cmp_lo   = (req_addr_i == ADDR_CMP_LO);
  assign sel_cmp_hi   = (req_addr_i == ADDR_CMP_HI);
  assign sel_mtime_lo = (req_addr_i == ADDR_MTIME_LO);
  assign sel_mtime_hi = (req_addr_i == ADDR_MTIME_HI);
  assign hit          = sel_msip | sel_cmp_lo | sel_cmp_hi | sel_mtime_lo | sel_mtime_hi;
  assign wr_en        = accept & req_we_i & hit & (|req_be_i);
  assign mtime_wr     = wr_en & (sel_mtime_lo | sel_mtime_hi);

`ifdef CLINT_PRESCALE_EN
  logic [15:0] presc_q;
  localparam logic [15:0] PRESC_LAST = 16'(TICK_DIV - 1);

  assign tick = (presc_q == PRESC_LAST);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      presc_q <= '0;
    end else if (mtime_wr || tick) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_q + 16'd1;
    end
  end
`else
  assign tick = 1'b1;
`endif

  always_comb begin
    rd_data = '0;
    unique case (1'b1)
      sel_msip:     rd_data = {31'd0, msip_q};
      sel_cmp_lo:   rd_data = mtimecmp_q[31:0];
      sel_cmp_hi:   rd_data = mtimecmp_q[63:32];
      sel_mtime_lo: rd_data = mtime_q[31:0];
      sel_mtime_hi: rd_data = mtime_q[63:32];
      default:      rd_data = '0;
    endcase
  end

  always_comb begin
    mtime_d    = mtime_q;
    mtimecmp_d = mtimecmp_q;
    msip_d     = msip_q;
    if (wr_en && sel_msip && req_be_i[0]) msip_d = req_wdata_i[0];
    if (wr_en && sel_cmp_lo) mtimecmp_d[31:0]  = merge_be(mtimecmp_q[31:0], req_wdata_i, req_be_i);
    if (wr_en && sel_cmp_hi) mtimecmp_d[63:32] = merge_be(mtimecmp_q[63:32], req_wdata_i, req_be_i);
    // A software write to mtime replaces that cycle's increment.
    if (mtime_wr && sel_mtime_lo) begin
      mtime_d[31:0] = merge_be(mtime_q[31:0], req_wdata_i, req_be_i);
    end else if (mtime_wr && sel_mtime_hi) begin
      mtime_d[63:32] = merge_be(mtime_q[63:32], req_wdata_i, req_be_i);
    end else if (tick) begin
      mtime_d = mtime_q + 64'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = RESP;
      RESP:    if (rsp_ready_i && !accept) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      mtime_q     <= '0;
      mtimecmp_q  <= '1;
      msip_q      <= 1'b0;
      timer_q     <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      msip_q     <= msip_d;
      timer_q    <= (mtime_q >= mtimecmp_q);
      if (accept) begin
        rsp_err_q   <= ~hit;
        rsp_rdata_q <= (req_we_i || !hit) ? 32'd0 : rd_data;
      end
    end
  end

  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;
  assign int_soft_o  = msip_q;
  assign int_timer_o = timer_q;

endmodule

// File: tb/tb_clint.sv
// Bench for clint: directed register-map checks, then randomized traffic against a time-based model.
module tb_clint;

`ifdef CLINT_PRESCALE_EN
  localparam int DIV = 4;
`else
  localparam int DIV = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready_o;
  logic        req_we = 1'b0;
  logic [15:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_be = '0;
  logic        rsp_valid_o;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic        int_soft_o;
  logic        int_timer_o;

  always #5 clk = ~clk;

`ifdef CLINT_PRESCALE_EN
  clint #(.TICK_DIV(DIV)) dut (
`else
  clint dut (
`endif
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready_o), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_be_i(req_be),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready),
    .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
    .int_soft_o(int_soft_o), .int_timer_o(int_timer_o)
  );

  typedef struct packed { logic err; logic [31:0] rdata; } rsp_t;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  rsp_t exp_q[$];

  // Model: mtime is a linear function of time since its last write (or reset).
  logic [63:0] mt_base = '0;
  int          mt_w = 0;
  logic [63:0] cmp_m = '1;
  logic        msip_m = 1'b0;
  bit          exp_timer = 1'b0;

  bit rr_rand = 1'b0;
  bit rr_fixed = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] mt_at(input int k);
    return mt_base + 64'((k - mt_w) / DIV);
  endfunction

  function automatic logic [31:0] merge32(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (be[i]) r[i*8 +: 8] = n[i*8 +: 8];
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_accept(input int e, input logic we, input logic [15:0] a,
                              input logic [31:0] wd, input logic [3:0] be);
    logic [63:0] cur;
    rsp_t r;
    bit hit;
    cur = mt_at(e - 1);
    hit = (a == 16'h0000) || (a == 16'h4000) || (a == 16'h4004) || (a == 16'hBFF8) || (a == 16'hBFFC);
    r.err = !hit;
    r.rdata = '0;
    if (hit && we) begin
      if (be != 4'b0000) begin
        case (a)
          16'h0000: if (be[0]) msip_m = wd[0];
          16'h4000: cmp_m[31:0]  = merge32(cmp_m[31:0], wd, be);
          16'h4004: cmp_m[63:32] = merge32(cmp_m[63:32], wd, be);
          16'hBFF8: begin mt_base = {cur[63:32], merge32(cur[31:0], wd, be)}; mt_w = e; end
          16'hBFFC: begin mt_base = {merge32(cur[63:32], wd, be), cur[31:0]}; mt_w = e; end
          default: ;
        endcase
      end
    end else if (hit) begin
      case (a)
        16'h0000: r.rdata = {31'd0, msip_m};
        16'h4000: r.rdata = cmp_m[31:0];
        16'h4004: r.rdata = cmp_m[63:32];
        16'hBFF8: r.rdata = cur[31:0];
        16'hBFFC: r.rdata = cur[63:32];
        default: ;
      endcase
    end
    exp_q.push_back(r);
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic xact(input logic we, input logic [15:0] a, input logic [31:0] wd, input logic [3:0] be);
    int guard = 0;
    bit done = 1'b0;
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd; req_be = be;
    while (!done) begin
      @(negedge clk);
      if (req_ready_o) begin
        @(posedge clk); #1;
        done = 1'b1;
        model_accept(cyc, we, a, wd, be);
      end else begin
        guard++;
        if (guard > 1000) begin
          checks++; failures++;
          $display("FAIL req_accept timeout addr=0x%0h", a);
          done = 1'b1;
        end else begin
          @(posedge clk); #1;
        end
      end
    end
    req_valid = 1'b0;
  endtask

  task automatic set_rr(input bit v);
    rr_fixed = v;
    rsp_ready = v;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = 1'b0;
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    mt_base = '0; mt_w = cyc; cmp_m = '1; msip_m = 1'b0;
    @(negedge clk);
    chk("rst_rsp_valid", rsp_valid_o, 0);
    chk("rst_req_ready", req_ready_o, 1);
    chk("rst_rsp_rdata", rsp_rdata_o, 0);
    chk("rst_rsp_err", rsp_err_o, 0);
    chk("rst_int_timer", int_timer_o, 0);
    chk("rst_int_soft", int_soft_o, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rr_rand) rsp_ready = ($urandom_range(0, 3) != 0);
      else rsp_ready = rr_fixed;
    end
  end

  // Monitor: interrupts every cycle, responses popped from the scoreboard when consumed.
  always @(negedge clk) begin
    if (rst) begin
      exp_timer = 1'b0;
    end else begin
      chk("int_timer", int_timer_o, exp_timer);
      chk("int_soft", int_soft_o, msip_m);
      chk("req_ready", req_ready_o, (!rsp_valid_o || rsp_ready));
      if (rsp_valid_o) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL rsp_unexpected rdata=0x%0h err=%0d expected no response", rsp_rdata_o, rsp_err_o);
        end else begin
          chk("rsp_err", rsp_err_o, exp_q[0].err);
          chk("rsp_rdata", rsp_rdata_o, exp_q[0].rdata);
          if (rsp_ready) void'(exp_q.pop_front());
        end
      end
      exp_timer = (mt_at(cyc) >= cmp_m);
    end
  end

  function automatic logic [15:0] pick_addr();
    case ($urandom_range(0, 11))
      0, 1:    return 16'h0000;
      2, 3:    return 16'h4000;
      4, 5:    return 16'h4004;
      6, 7:    return 16'hBFF8;
      8:       return 16'hBFFC;
      9:       return 16'h0008;
      10:      return 16'h4002;
      default: return 16'hBFF9;
    endcase
  endfunction

  initial begin
    int w, rise, hi_cnt, gap;
    do_reset();

    xact(0, 16'h4000, 0, 4'hF);
    xact(0, 16'h4004, 0, 4'hF);

    xact(1, 16'h0000, 32'hFFFF_FFFF, 4'hF);
    @(negedge clk);
    chk("msip_soft_with_rsp", int_soft_o & rsp_valid_o, 1);
    @(posedge clk); #1;
    xact(0, 16'h0000, 0, 4'hF);
    xact(1, 16'h0000, 32'h0, 4'hF);

    xact(1, 16'h4004, 32'h0, 4'hF);
    xact(1, 16'h4000, 32'd20, 4'hF);
    xact(1, 16'hBFF8, 32'h0, 4'hF);
    w = cyc;
    rise = -1;
    for (int i = 0; i < 200 && rise < 0; i++) begin
      @(negedge clk);
      if (int_timer_o) rise = cyc;
    end
    chk("timer_rise_delay", rise - w, 20 * DIV + 1);
    @(posedge clk); #1;
    xact(1, 16'h4000, 32'd1000, 4'hF);
    @(negedge clk);
    chk("timer_before_fall", int_timer_o, 1);
    @(negedge clk);
    chk("timer_fall", int_timer_o, 0);
    @(posedge clk); #1;

    xact(1, 16'hBFF8, 32'hFFFF_FFFE, 4'hF);
    xact(1, 16'hBFFC, 32'h0, 4'hF);
    repeat (4 * DIV) @(posedge clk);
    #1;
    xact(0, 16'hBFFC, 0, 4'hF);
    @(negedge clk);
    chk("carry_hi", rsp_rdata_o, 1);
    @(posedge clk); #1;
    xact(0, 16'hBFF8, 0, 4'hF);

    xact(1, 16'hBFF8, 32'h1234_5678, 4'h0);
    xact(0, 16'hBFF8, 0, 4'hF);

    xact(0, 16'h0008, 0, 4'hF);
    xact(0, 16'h4002, 0, 4'hF);
    xact(1, 16'h4002, 32'hDEAD_BEEF, 4'hF);
    xact(1, 16'hBFFA, 32'hDEAD_BEEF, 4'hF);
    xact(0, 16'h4000, 0, 4'hF);
    repeat (2) @(posedge clk);
    #1;
    set_rr(0);
    xact(0, 16'h0008, 0, 4'hF);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_rsp_valid", rsp_valid_o, 1);
      chk("hold_req_ready", req_ready_o, 0);
      chk("hold_rsp_err", rsp_err_o, 1);
      chk("hold_rsp_rdata", rsp_rdata_o, 0);
    end
    @(posedge clk); #1;
    set_rr(1);

`ifdef CLINT_PRESCALE_EN
    xact(1, 16'hBFFC, 32'h0, 4'hF);
    xact(1, 16'hBFF8, 32'h0, 4'hF);
    repeat (40) @(posedge clk);
    #1;
    xact(0, 16'hBFF8, 0, 4'hF);
    @(negedge clk);
    chk("presc_mtime_lo", rsp_rdata_o, 10);
    @(posedge clk); #1;
    xact(1, 16'hBFF8, 32'h0000_AB00, 4'b0010);
    xact(0, 16'hBFF8, 0, 4'hF);
`endif

    xact(1, 16'h4004, 32'hFFFF_FFFF, 4'hF);
    xact(1, 16'h4000, 32'hFFFF_FFFF, 4'hF);
    xact(1, 16'hBFF8, 32'hFFFF_FFF0, 4'hF);
    xact(1, 16'hBFFC, 32'hFFFF_FFFF, 4'hF);
    hi_cnt = 0;
    for (int i = 0; i < 30 * DIV; i++) begin
      @(negedge clk);
      if (int_timer_o) hi_cnt++;
    end
    chk("wrap_timer_pulse_len", hi_cnt, DIV);
    @(posedge clk); #1;

    rr_rand = 1'b1;
    for (int n = 0; n < 300; n++) begin
      xact($urandom_range(0, 1), pick_addr(), $urandom, 4'($urandom_range(0, 15)));
      gap = $urandom_range(0, 2);
      if (gap > 0) begin
        repeat (gap) @(posedge clk);
        #1;
      end
    end
    rr_rand = 1'b0;
    set_rr(1);
    for (int i = 0; i < 20 && (exp_q.size() != 0 || rsp_valid_o); i++) @(posedge clk);
    #1;
    chk("queue_drain", exp_q.size(), 0);

    set_rr(0);
    xact(0, 16'h4000, 0, 4'hF);
    do_reset();
    set_rr(1);
    xact(0, 16'h4004, 0, 4'hF);
    repeat (3) @(posedge clk);
    #1;
    chk("queue_drain_after_reset", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
